ifu: RTL and testbench

//  Instruction fetch unit: feeds 32-bit instruction words and their PC to the decode stage (idu inst_i).

---
 rtl/ifu.sv | 143 ++++++++++++++
 tb/tb_ifu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC and keeps one instruction-memory
// request outstanding at a time. The fetched word is held for decode behind
// a valid/ready handshake. Execute/branch redirects are accepted in any state.
// Optional feature macro: YSYX_23060251_IFU_MISALIGN_CHECK_EN. When it is
// defined, a PC that is not word aligned faults locally and no memory request
// is issued.
module ifu #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'('h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              imem_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              fault_o,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic              drop, drop_n;
  logic [INST_W-1:0] inst_q, inst_n;
  logic [PC_W-1:0]   pco_q, pco_n;
  logic              fault_q, fault_n;
  logic              misalign;
  logic              req_fire;

  // Misaligned PCs fault locally only when the check is built in.
`ifdef YSYX_23060251_IFU_MISALIGN_CHECK_EN
  assign misalign = |pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign req_fire = imem_req_valid_o && imem_req_ready_i;

  // State, PC, drop flag and the registered decode-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst_q  <= '0;
      pco_q   <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      drop    <= drop_n;
      inst_q  <= inst_n;
      pco_q   <= pco_n;
      fault_q <= fault_n;
    end
  end

  // Next state. A redirect beats every other event. A request that is already
  // accepted cannot be recalled, so its response is marked for discard.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    inst_n  = inst_q;
    pco_n   = pco_q;
    fault_n = fault_q;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_i) pc_n = redirect_pc_i;
      end
      REQ: begin
        if (redirect_i) begin
          pc_n = redirect_pc_i;
          if (req_fire) begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end else if (misalign) begin
          state_n = OUT;
          inst_n  = '0;
          fault_n = 1'b1;
          pco_n   = pc;
        end else if (req_fire) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          pc_n = redirect_pc_i;
          if (imem_resp_valid_i) begin
            state_n = REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem_resp_valid_i) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            inst_n  = imem_err_i ? '0 : imem_rdata_i;
            fault_n = imem_err_i;
            pco_n   = pc;
            state_n = OUT;
          end
        end
      end
      OUT: begin
        if (redirect_i) begin
          pc_n    = redirect_pc_i;
          state_n = REQ;
        end else if (inst_ready_i) begin
          pc_n    = pc + PC_W'(4);
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state. The address follows the PC, so
  // it stays stable while a request waits for ready.
  always_comb begin
    imem_req_valid_o = (state == REQ) && !misalign;
    imem_addr_o      = pc;
    inst_valid_o     = (state == OUT);
    inst_o           = inst_q;
    pc_o             = pco_q;
    fault_o          = fault_q;
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu. A table of fetches is followed by hand-written
// redirect, reset and misalignment sequences. The memory side is driven by the
// bench. Expected decode outputs are queued when each response is driven and
// popped when decode sees inst_valid.
module tb_ifu;
  localparam int          PC_W  = 64;
  localparam int          INST_W = 32;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [PC_W-1:0]   imem_addr_o;
  logic              imem_resp_valid_i;
  logic [INST_W-1:0] imem_rdata_i;
  logic              imem_err_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [PC_W-1:0]   pc_o;
  logic              fault_o;
  logic              redirect_i;
  logic [PC_W-1:0]   redirect_pc_i;

  ifu #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_resp_valid_i(imem_resp_valid_i),
    .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .fault_o(fault_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic        err;
    int          stall;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  vec_t vt[5];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_req;
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("req_wait", 64'(ok), 64'd1);
  endtask

  // Pop the scoreboard and compare it with what decode currently sees.
  task automatic check_out;
    exp_t e;
    chk("inst_valid", 64'(inst_valid_o), 64'd1);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got output with no expected entry");
    end else begin
      e = sbq.pop_front();
      chk("inst", 64'(inst_o), 64'(e.inst));
      chk("pc", pc_o, e.pc);
      chk("fault", 64'(fault_o), 64'(e.fault));
    end
  endtask

  task automatic fetch_to_out(input logic [63:0] pc, input logic [31:0] data, input logic err);
    exp_t e;
    wait_req();
    chk("req_addr", imem_addr_o, pc);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    chk("one_outstanding", 64'(imem_req_valid_o), 64'd0);
    e.pc = pc;
    e.inst = err ? 32'h0 : data;
    e.fault = err;
    sbq.push_back(e);
    imem_resp_valid_i = 1'b1;
    imem_rdata_i = data;
    imem_err_i = err;
    tick();
    imem_resp_valid_i = 1'b0;
    imem_err_i = 1'b0;
    check_out();
  endtask

  task automatic accept;
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] pc, input logic [31:0] data, input logic err, input int stall);
    fetch_to_out(pc, data, err);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 64'(inst_valid_o), 64'd1);
      chk("stall_inst", 64'(inst_o), 64'(err ? 32'h0 : data));
      chk("stall_pc", pc_o, pc);
      chk("stall_noreq", 64'(imem_req_valid_o), 64'd0);
    end
    accept();
  endtask

  task automatic chk_reset_outputs;
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("rst_addr", imem_addr_o, RPC);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_pc_o", pc_o, RPC);
    chk("rst_fault", 64'(fault_o), 64'd0);
  endtask

  initial begin
    vt[0] = '{pc: 64'h8000_0000, data: 32'h0000_0013, err: 1'b0, stall: 0};
    vt[1] = '{pc: 64'h8000_0004, data: 32'h0040_0093, err: 1'b0, stall: 5};
    vt[2] = '{pc: 64'h8000_0008, data: 32'h0080_0113, err: 1'b0, stall: 0};
    vt[3] = '{pc: 64'h8000_000C, data: 32'hDEAD_BEEF, err: 1'b1, stall: 0};
    vt[4] = '{pc: 64'h8000_0010, data: 32'h1234_5678, err: 1'b0, stall: 2};

    rst = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_rdata_i = '0;
    imem_err_i = 1'b0;
    inst_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    tick();
    tick();
    chk_reset_outputs();

    // One bubble after reset release before the first request.
    rst = 1'b0;
    chk("bubble", 64'(imem_req_valid_o), 64'd0);
    tick();
    chk("first_req", 64'(imem_req_valid_o), 64'd1);

    for (int i = 0; i < 5; i++) fetch(vt[i].pc, vt[i].data, vt[i].err, vt[i].stall);

    // Redirect while waiting; the stale response arrives two cycles later.
    wait_req();
    chk("t3_addr", imem_addr_o, 64'h8000_0014);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    tick();
    redirect_i = 1'b0;
    tick();
    imem_resp_valid_i = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("t3_dropped", 64'(inst_valid_o), 64'd0);
    chk("t3_req", 64'(imem_req_valid_o), 64'd1);
    chk("t3_new_addr", imem_addr_o, 64'h8000_0100);
    fetch(64'h8000_0100, 32'h00A0_0193, 1'b0, 0);

    // Redirect in OUT with a same-cycle decode accept: the accept is void.
    fetch_to_out(64'h8000_0104, 32'h00B0_0213, 1'b0);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    inst_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    inst_ready_i = 1'b0;
    chk("t4_valid_drop", 64'(inst_valid_o), 64'd0);
    chk("t4_req", 64'(imem_req_valid_o), 64'd1);
    chk("t4_addr", imem_addr_o, 64'h8000_0200);
    fetch(64'h8000_0200, 32'h00C0_0293, 1'b0, 1);

    // Redirect in the same cycle the request is accepted.
    wait_req();
    chk("rq_addr", imem_addr_o, 64'h8000_0204);
    imem_req_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0300;
    tick();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b0;
    chk("rq_wait", 64'(imem_req_valid_o), 64'd0);
    imem_resp_valid_i = 1'b1;
    imem_rdata_i = 32'hBAD1_BAD1;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("rq_dropped", 64'(inst_valid_o), 64'd0);
    chk("rq_new_addr", imem_addr_o, 64'h8000_0300);
    fetch(64'h8000_0300, 32'h00D0_0313, 1'b0, 0);

    // Reset during WAIT; the in-flight response lands after release.
    wait_req();
    chk("t6_addr", imem_addr_o, 64'h8000_0304);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_outputs();
    rst = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_rdata_i = 32'hBAD2_BAD2;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("t6_ignored", 64'(inst_valid_o), 64'd0);
    chk("t6_req", 64'(imem_req_valid_o), 64'd1);
    chk("t6_req_addr", imem_addr_o, RPC);
    fetch(RPC, 32'h0000_0013, 1'b0, 0);

    // Redirect to a misaligned PC.
    wait_req();
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0102;
    tick();
    redirect_i = 1'b0;
`ifdef YSYX_23060251_IFU_MISALIGN_CHECK_EN
    chk("mis_noreq", 64'(imem_req_valid_o), 64'd0);
    sbq.push_back('{pc: 64'h8000_0102, inst: 32'h0, fault: 1'b1});
    tick();
    check_out();
    accept();
`else
    chk("mis_req", 64'(imem_req_valid_o), 64'd1);
    chk("mis_addr", imem_addr_o, 64'h8000_0102);
    fetch(64'h8000_0102, 32'h00E0_0393, 1'b0, 0);
`endif
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0400;
    tick();
    redirect_i = 1'b0;
    fetch(64'h8000_0400, 32'h00F0_0413, 1'b0, 0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
